// File: rtl/stopwatch_core_if.sv
// Signal bundle between the button debouncers, the stopwatch core and the display scan stage.
// All members are plain levels with no valid/ready handshake: inputs are sampled every clk edge, outputs are registered and always valid.
interface stopwatch_core_if;
   logic       sel_db;
   logic       adj_db;
   logic       clr_db;
   logic       pause_db;
   logic [3:0] min_tens;
   logic [3:0] min_ones;
   logic [3:0] sec_tens;
   logic [3:0] sec_ones;
   logic       paused;
   logic       adj_sel;
   logic       blink_on;

   modport master (
      output sel_db, adj_db, clr_db, pause_db,
      input  min_tens, min_ones, sec_tens, sec_ones, paused, adj_sel, blink_on
   );

   modport slave (
      input  sel_db, adj_db, clr_db, pause_db,
      output min_tens, min_ones, sec_tens, sec_ones, paused, adj_sel, blink_on
   );
endinterface

// File: rtl/stopwatch_core.sv
// MM:SS stopwatch with pause toggle, 2 Hz field adjust and clear.
// Keeps four BCD digits and display status flags; every output is registered.
module stopwatch_core #(
   parameter int unsigned DIV_1HZ = 100000000,
   parameter int unsigned DIV_2HZ = 50000000,
   parameter int unsigned CNT_W   = 27
) (
   input logic             clk,
   input logic             rst,
   stopwatch_core_if.slave sw
);

   typedef enum logic [1:0] {
      MODE_RUN    = 2'd0,
      MODE_ADJUST = 2'd1,
      MODE_CLEAR  = 2'd2
   } mode_t;

   localparam logic [CNT_W-1:0] P1_LAST = CNT_W'(DIV_1HZ - 1);
   localparam logic [CNT_W-1:0] P2_LAST = CNT_W'(DIV_2HZ - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] p1;
   logic [CNT_W-1:0] p2;
   logic             pause_q;
   logic             paused_r;
   logic             adj_sel_r;
   logic             blink_r;
   logic [3:0]       min_tens_r;
   logic [3:0]       min_ones_r;
   logic [3:0]       sec_tens_r;
   logic [3:0]       sec_ones_r;

   mode_t            mode;
   logic             counting;
   logic             tick1;
   logic             tick2;
   logic             pause_rise;
   logic             sec_wrap;
   logic [7:0]       sec_next;
   logic [7:0]       min_next;

   // Increment a 00..59 BCD pair; 59 rolls over to 00.
   function automatic logic [7:0] bcd60_inc(input logic [3:0] tens, input logic [3:0] ones);
      logic [7:0] r;
      if (ones != 4'd9) begin
         r = {tens, ones + 4'd1};
      end else if (tens != 4'd5) begin
         r = {tens + 4'd1, 4'd0};
      end else begin
         r = 8'h00;
      end
      return r;
   endfunction

   always_comb begin
      mode = MODE_RUN;
      if (sw.clr_db) begin
         mode = MODE_CLEAR;
      end else if (sw.adj_db) begin
         mode = MODE_ADJUST;
      end
      counting   = (mode == MODE_RUN) && !paused_r;
      tick1      = counting && (p1 == P1_LAST);
      tick2      = (p2 == P2_LAST);
      pause_rise = sw.pause_db & ~pause_q;
      sec_wrap   = (sec_tens_r == 4'd5) && (sec_ones_r == 4'd9);
      sec_next   = bcd60_inc(sec_tens_r, sec_ones_r);
      min_next   = bcd60_inc(min_tens_r, min_ones_r);
   end

   // P1 keeps a partial second across pause/adjust so resuming is seamless.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p1 <= '0;
         p2 <= '0;
      end else begin
         p2 <= tick2 ? '0 : p2 + CNT_ONE;
         if (mode == MODE_CLEAR) begin
            p1 <= '0;
         end else if (counting) begin
            p1 <= tick1 ? '0 : p1 + CNT_ONE;
         end
      end
   end

   // Pause toggles on every rising edge of the level, whatever the mode.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pause_q   <= 1'b0;
         paused_r  <= 1'b0;
         adj_sel_r <= 1'b0;
         blink_r   <= 1'b1;
      end else begin
         pause_q   <= sw.pause_db;
         adj_sel_r <= sw.sel_db;
         if (pause_rise) begin
            paused_r <= ~paused_r;
         end
         if (!sw.adj_db) begin
            blink_r <= 1'b1;
         end else if (tick2) begin
            blink_r <= ~blink_r;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         min_tens_r <= 4'd0;
         min_ones_r <= 4'd0;
         sec_tens_r <= 4'd0;
         sec_ones_r <= 4'd0;
      end else begin
         unique case (mode)
            MODE_CLEAR: begin
               min_tens_r <= 4'd0;
               min_ones_r <= 4'd0;
               sec_tens_r <= 4'd0;
               sec_ones_r <= 4'd0;
            end
            MODE_ADJUST: begin
               // Adjusting one field never carries into the other.
               if (tick2) begin
                  if (sw.sel_db) begin
                     {sec_tens_r, sec_ones_r} <= sec_next;
                  end else begin
                     {min_tens_r, min_ones_r} <= min_next;
                  end
               end
            end
            default: begin
               if (tick1) begin
                  {sec_tens_r, sec_ones_r} <= sec_next;
                  if (sec_wrap) begin
                     {min_tens_r, min_ones_r} <= min_next;
                  end
               end
            end
         endcase
      end
   end

   assign sw.min_tens = min_tens_r;
   assign sw.min_ones = min_ones_r;
   assign sw.sec_tens = sec_tens_r;
   assign sw.sec_ones = sec_ones_r;
   assign sw.paused   = paused_r;
   assign sw.adj_sel  = adj_sel_r;
   assign sw.blink_on = blink_r;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core with a seconds-count reference model.
module tb_stopwatch_core;
  localparam int DIV1 = 10;
  localparam int DIV2 = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic chk_on = 1'b0;
  int   total_n = 0;
  int   bad_n = 0;

  stopwatch_core_if sw();

  stopwatch_core #(.DIV_1HZ(DIV1), .DIV_2HZ(DIV2), .CNT_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .sw(sw)
  );

  always #5 clk = ~clk;

  logic [15:0] dut_digits;
  logic [2:0]  dut_flags;
  assign dut_digits = {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones};
  assign dut_flags  = {sw.paused, sw.adj_sel, sw.blink_on};

  // Model state: elapsed time as a plain seconds count 0..3599.
  typedef struct {
    int total;
    int p1;
    int p2;
    bit paused;
    bit pq;
    bit blink;
    bit sel;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.total = 0; r.p1 = 0; r.p2 = 0;
    r.paused = 0; r.pq = 0; r.blink = 1; r.sel = 0;
    return r;
  endfunction

  function automatic model_t step(model_t c, logic sel, logic adj, logic clr, logic pz);
    model_t n;
    bit run_c, t1, t2;
    int mn, sc;
    n = c;
    mn = c.total / 60;
    sc = c.total % 60;
    t2 = (c.p2 == DIV2 - 1);
    run_c = !clr && !adj && !c.paused;
    t1 = run_c && (c.p1 == DIV1 - 1);
    if (clr) n.total = 0;
    else if (adj) begin
      if (t2 && sel) n.total = mn * 60 + (sc + 1) % 60;
      else if (t2) n.total = ((mn + 1) % 60) * 60 + sc;
    end else if (t1) n.total = (c.total + 1) % 3600;
    if (clr) n.p1 = 0;
    else if (run_c) n.p1 = (c.p1 + 1) % DIV1;
    n.p2 = (c.p2 + 1) % DIV2;
    if (pz && !c.pq) n.paused = !c.paused;
    n.pq = pz;
    n.blink = adj ? (t2 ? !c.blink : c.blink) : 1'b1;
    n.sel = sel;
    return n;
  endfunction

  function automatic logic [15:0] exp_digits(int t);
    int mn, sc;
    mn = t / 60;
    sc = t % 60;
    return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10)};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= model_reset();
    else m <= step(m, sw.sel_db, sw.adj_db, sw.clr_db, sw.pause_db);
  end

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    total_n++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every cycle out of reset, DUT outputs against the model.
  always @(negedge clk) begin
    if (rst && chk_on) begin
      chk("digits", dut_digits, exp_digits(m.total));
      chk("flags", 16'(dut_flags), 16'({m.paused, m.sel, m.blink}));
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic adj_to(int mins, int secs);
    int guard;
    sw.adj_db = 1'b1;
    sw.sel_db = 1'b0;
    guard = 0;
    while (m.total / 60 != mins && guard < 400) begin cyc(1); guard++; end
    chk("adj_min_reach", 16'(guard < 400), 16'd1);
    sw.sel_db = 1'b1;
    guard = 0;
    while (m.total % 60 != secs && guard < 400) begin cyc(1); guard++; end
    chk("adj_sec_reach", 16'(guard < 400), 16'd1);
  endtask

  task automatic pulse_pause(int n);
    sw.pause_db = 1'b1;
    cyc(n);
    sw.pause_db = 1'b0;
  endtask

  initial begin
    sw.sel_db = 1'b0; sw.adj_db = 1'b0; sw.clr_db = 1'b0; sw.pause_db = 1'b0;
    rst = 1'b0;
    cyc(3);
    rst = 1'b1;
    #1;
    chk("rst_digits", dut_digits, 16'h0000);
    chk("rst_flags", 16'(dut_flags), 16'h0001);
    chk_on = 1'b1;

    // Run wrap: preload 59:58, then count through the hour boundary.
    adj_to(59, 58);
    sw.adj_db = 1'b0;
    chk("preload", dut_digits, 16'h5958);
    cyc(10); chk("run_5959", dut_digits, 16'h5959);
    cyc(10); chk("run_wrap", dut_digits, 16'h0000);
    cyc(90); chk("run_0009", dut_digits, 16'h0009);
    cyc(10); chk("run_0010", dut_digits, 16'h0010);

    // Pause keeps the partial second.
    sw.clr_db = 1'b1;
    cyc(2); chk("clear", dut_digits, 16'h0000);
    sw.clr_db = 1'b0;
    cyc(34); chk("run_0003", dut_digits, 16'h0003);
    sw.pause_db = 1'b1;
    cyc(1); chk("paused_on", 16'(dut_flags), 16'h0007);
    cyc(2); sw.pause_db = 1'b0;
    cyc(47); chk("pause_frozen", dut_digits, 16'h0003);
    pulse_pause(3);
    cyc(2); chk("resume_partial", dut_digits, 16'h0003);
    chk("paused_off", 16'(dut_flags), 16'h0003);
    cyc(1); chk("resume_tick", dut_digits, 16'h0004);

    // Adjust: seconds wrap without carry, then minutes, blink released.
    adj_to(0, 58);
    chk("adj_0058", dut_digits, 16'h0058);
    cyc(15); chk("adj_sec_wrap", dut_digits, 16'h0001);
    sw.sel_db = 1'b0;
    cyc(10); chk("adj_min_step", dut_digits, 16'h0201);
    sw.adj_db = 1'b0;
    cyc(1); chk("blink_release", 16'(dut_flags), 16'h0001);

    // Pause edge inside adjust keeps counting frozen after release.
    sw.adj_db = 1'b1;
    pulse_pause(2);
    sw.adj_db = 1'b0;
    cyc(1); chk("adj_pause_flags", 16'(dut_flags), 16'h0005);
    cyc(29); chk("adj_pause_frozen", dut_digits, 16'h0201);
    pulse_pause(1);
    chk("adj_unpause", 16'(dut_flags), 16'h0001);
    cyc(8); chk("unpause_pre", dut_digits, 16'h0201);
    cyc(1); chk("unpause_tick", dut_digits, 16'h0202);

    // Pause rise on the tick cycle: tick lands, then frozen.
    cyc(9);
    pulse_pause(1);
    chk("tick_with_pause", dut_digits, 16'h0203);
    chk("tick_pause_flags", 16'(dut_flags), 16'h0005);
    cyc(15); chk("tick_pause_frozen", dut_digits, 16'h0203);

    // Clear beats adjust on a tick2 cycle; paused untouched.
    adj_to(12, 34);
    chk("adj_1234", dut_digits, 16'h1234);
    cyc(4);
    sw.clr_db = 1'b1;
    cyc(1); chk("clr_over_adj", dut_digits, 16'h0000);
    chk("clr_keeps_pause", 16'(sw.paused), 16'h0001);
    cyc(5); chk("clr_hold", dut_digits, 16'h0000);
    sw.clr_db = 1'b0;
    sw.adj_db = 1'b0;
    cyc(20); chk("clr_paused_frozen", dut_digits, 16'h0000);
    pulse_pause(1);
    cyc(10); chk("clr_resume", dut_digits, 16'h0001);

    // Asynchronous reset mid-count.
    adj_to(3, 27);
    sw.adj_db = 1'b0;
    cyc(5); chk("pre_rst", dut_digits, 16'h0327);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_digits", dut_digits, 16'h0000);
    chk("async_rst_flags", 16'(dut_flags), 16'h0001);
    @(negedge clk);
    rst = 1'b1;
    cyc(20); chk("post_rst_run", dut_digits, 16'h0002);

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end
endmodule
